// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame scheduler: sequencer states and default sizing.
package fft_pkg;

    localparam int FFT_LEN_DEF = 128;
    localparam int DATA_W_DEF  = 16;
    localparam int GAP_CYC_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/st_hold_reg.sv
// One-deep Avalon-ST hold register with sop/eop sidebands.
// A push is taken when the slot is empty or drains this cycle, otherwise it is reported as a drop.
module st_hold_reg
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_sop,
    input  logic              push_eop,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              sop,
    output logic              eop,
    output logic              xfer,
    output logic              drop
);

    logic accept;

    assign xfer   = valid && ready;
    assign accept = push && (!valid || ready);
    assign drop   = push && valid && !ready;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            sop   <= 1'b0;
            eop   <= 1'b0;
        end else if (accept) begin
            data  <= push_data;
            valid <= 1'b1;
            sop   <= push_sop;
            eop   <= push_eop;
        end else if (xfer) begin
            // sidebands cleared with valid so they never linger unqualified
            valid <= 1'b0;
            sop   <= 1'b0;
            eop   <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame sequencer feeding whole FFT_LEN-sample frames from the audio strobe into the FFT sink,
// with a guaranteed idle gap between frames and a saturating count of overflow drops.
//
// state | meaning
// IDLE  | waiting for a sample while frame_grant is high
// FILL  | frame in progress, idx counts transfers
// GAP   | post-frame idle, gap_cnt counts down to IDLE
module fft_frame_sched
    import fft_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] audio_data,
    input  logic              audio_valid,
    input  logic              frame_grant,
    input  logic              fft_sink_ready,
    output logic [DATA_W-1:0] fft_sink_data,
    output logic              fft_sink_valid,
    output logic              fft_sink_sop,
    output logic              fft_sink_eop,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int IDX_W = $clog2(FFT_LEN);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] load_idx;
    logic             push;
    logic             push_sop;
    logic             push_eop;
    logic             eop_pending;
    logic             late_drop;
    logic             drop;
    logic             h_xfer;
    logic             h_drop;

    // The untransferred sample (if any) has index idx, so a new load is idx + occupancy.
    always_comb begin
        eop_pending = fft_sink_valid && fft_sink_eop;
        load_idx    = idx + IDX_W'(fft_sink_valid);
        push        = 1'b0;
        push_sop    = 1'b0;
        push_eop    = 1'b0;
        late_drop   = 1'b0;
        case (state)
            ST_IDLE: begin
                push     = audio_valid && frame_grant;
                push_sop = 1'b1;
            end
            ST_FILL: begin
                // past the eop sample the frame is closed; a sample meeting the eop transfer is just discarded
                if (eop_pending) begin
                    late_drop = audio_valid && !fft_sink_ready;
                end else begin
                    push     = audio_valid;
                    push_eop = (load_idx == IDX_LAST);
                end
            end
            default: ;
        endcase
        drop = h_drop || late_drop;
    end

    st_hold_reg #(.DATA_W(DATA_W)) u_hold (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (audio_data),
        .push_sop  (push_sop),
        .push_eop  (push_eop),
        .ready     (fft_sink_ready),
        .data      (fft_sink_data),
        .valid     (fft_sink_valid),
        .sop       (fft_sink_sop),
        .eop       (fft_sink_eop),
        .xfer      (h_xfer),
        .drop      (h_drop)
    );

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            gap_cnt    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (push) begin
                        state <= ST_FILL;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end
                ST_FILL: begin
                    if (h_xfer) begin
                        if (fft_sink_eop) begin
                            state      <= ST_GAP;
                            busy       <= 1'b0;
                            idx        <= '0;
                            gap_cnt    <= GAP_LOAD;
                            frame_done <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state   <= ST_IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: frame assembly, back-pressure drops, grant gating,
// inter-frame gap, drop counter saturation and mid-frame reset.
module tb_fft_frame_sched;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        frame_grant;
    logic        fft_sink_ready;
    logic [15:0] fft_sink_data;
    logic        fft_sink_valid;
    logic        fft_sink_sop;
    logic        fft_sink_eop;
    logic        frame_done;
    logic        busy;
    logic [7:0]  drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    fft_frame_sched dut (
        .clk_50m        (clk_50m),
        .rst_n          (rst_n),
        .audio_data     (audio_data),
        .audio_valid    (audio_valid),
        .frame_grant    (frame_grant),
        .fft_sink_ready (fft_sink_ready),
        .fft_sink_data  (fft_sink_data),
        .fft_sink_valid (fft_sink_valid),
        .fft_sink_sop   (fft_sink_sop),
        .fft_sink_eop   (fft_sink_eop),
        .frame_done     (frame_done),
        .busy           (busy),
        .drop_cnt       (drop_cnt)
    );

    initial forever #5 clk_50m = ~clk_50m;

    // transfer log, filled on the falling edge
    logic [15:0] x_data[$];
    bit          x_sop[$];
    bit          x_eop[$];
    int          x_cyc[$];
    int          done_cyc[$];
    int          valid_cnt = 0;
    int          unstable  = 0;
    int          cyc       = 0;
    logic        p_valid   = 1'b0;
    logic        p_ready   = 1'b1;
    logic [15:0] p_data    = '0;

    initial forever begin
        @(negedge clk_50m);
        cyc++;
        if (fft_sink_valid === 1'b1) valid_cnt++;
        if (p_valid === 1'b1 && p_ready === 1'b0 &&
            (fft_sink_valid !== 1'b1 || fft_sink_data !== p_data)) unstable++;
        if (fft_sink_valid === 1'b1 && fft_sink_ready === 1'b1) begin
            x_data.push_back(fft_sink_data);
            x_sop.push_back(fft_sink_sop);
            x_eop.push_back(fft_sink_eop);
            x_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) done_cyc.push_back(cyc);
        p_valid = fft_sink_valid;
        p_ready = fft_sink_ready;
        p_data  = fft_sink_data;
    end

    function automatic int qd(input int i);
        return (i >= 0 && i < x_data.size()) ? int'(x_data[i]) : -1;
    endfunction
    function automatic int qs(input int i);
        return (i >= 0 && i < x_sop.size()) ? int'(x_sop[i]) : -1;
    endfunction
    function automatic int qe(input int i);
        return (i >= 0 && i < x_eop.size()) ? int'(x_eop[i]) : -1;
    endfunction
    function automatic int qc(input int i);
        return (i >= 0 && i < x_cyc.size()) ? x_cyc[i] : -1000;
    endfunction
    function automatic int qdone(input int i);
        return (i >= 0 && i < done_cyc.size()) ? done_cyc[i] : -2000;
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        x_data.delete();
        x_sop.delete();
        x_eop.delete();
        x_cyc.delete();
        done_cyc.delete();
        valid_cnt = 0;
        unstable  = 0;
    endtask

    // one strobe followed by three quiet cycles
    task automatic send4(input int d);
        audio_valid = 1'b1;
        audio_data  = 16'(d);
        tick();
        audio_valid = 1'b0;
        idle(3);
    endtask

    task automatic check_frame(input string tag, input int b, input int first_d, input int last_d);
        int sops = 0;
        int eops = 0;
        for (int i = b; i < b + 128; i++) begin
            if (qs(i) == 1) sops++;
            if (qe(i) == 1) eops++;
        end
        check_val({tag, "_sop_count"}, sops, 1);
        check_val({tag, "_eop_count"}, eops, 1);
        check_val({tag, "_first_data"}, qd(b), first_d);
        check_val({tag, "_first_sop"}, qs(b), 1);
        check_val({tag, "_last_data"}, qd(b + 127), last_d);
        check_val({tag, "_last_eop"}, qe(b + 127), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, int'(fft_sink_valid), 0);
        check_val({tag, "_sop"}, int'(fft_sink_sop), 0);
        check_val({tag, "_eop"}, int'(fft_sink_eop), 0);
        check_val({tag, "_data"}, int'(fft_sink_data), 0);
        check_val({tag, "_done"}, int'(frame_done), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_drops"}, int'(drop_cnt), 0);
    endtask

    initial begin
        int bad;
        rst_n          = 1'b0;
        audio_data     = '0;
        audio_valid    = 1'b0;
        frame_grant    = 1'b0;
        fft_sink_ready = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // ramp frame, samples every 4 cycles
        clear_mon();
        frame_grant    = 1'b1;
        fft_sink_ready = 1'b1;
        for (int k = 0; k < 128; k++) send4(k);
        idle(4);
        check_val("f1_xfers", x_data.size(), 128);
        check_frame("f1", 0, 0, 127);
        bad = 0;
        for (int i = 0; i < 128; i++) if (qd(i) != i) bad++;
        check_val("f1_ramp_errors", bad, 0);
        check_val("f1_done_count", done_cyc.size(), 1);
        check_val("f1_done_delay", qdone(0) - qc(127), 1);
        check_val("f1_drops", int'(drop_cnt), 0);
        check_val("f1_busy_after", int'(busy), 0);
        idle(25);

        // ready low 10 cycles while sample 40 is held: samples 41 and 42 are lost
        clear_mon();
        for (int c = 0; c < 520; c++) begin
            audio_valid    = (c % 4 == 0);
            audio_data     = 16'(c / 4);
            fft_sink_ready = !(c >= 161 && c < 171);
            tick();
        end
        audio_valid    = 1'b0;
        fft_sink_ready = 1'b1;
        idle(4);
        check_val("f2_xfers", x_data.size(), 128);
        check_frame("f2", 0, 0, 129);
        check_val("f2_data40", qd(40), 40);
        check_val("f2_data41", qd(41), 43);
        check_val("f2_hold_stable", unstable, 0);
        check_val("f2_drops", int'(drop_cnt), 2);
        check_val("f2_done_count", done_cyc.size(), 1);
        idle(25);

        // no grant: everything discarded, uncounted
        clear_mon();
        frame_grant = 1'b0;
        for (int k = 0; k < 50; k++) send4(1000 + k);
        check_val("f3_no_valid", valid_cnt, 0);
        check_val("f3_idle_busy", int'(busy), 0);
        frame_grant = 1'b1;
        for (int k = 0; k < 128; k++) send4(2000 + k);
        idle(4);
        check_val("f3_xfers", x_data.size(), 128);
        check_frame("f3", 0, 2000, 2127);
        check_val("f3_drops", int'(drop_cnt), 2);
        idle(25);

        // continuous samples: back-to-back frames separated by the gap; grant drops mid frame B
        clear_mon();
        for (int c = 0; c <= 272; c++) begin
            audio_valid = 1'b1;
            audio_data  = 16'(3000 + c);
            frame_grant = (c < 150);
            tick();
        end
        audio_valid = 1'b0;
        idle(4);
        check_val("f4_xfers", x_data.size(), 256);
        check_frame("f4a", 0, 3000, 3127);
        check_frame("f4b", 128, 3145, 3272);
        check_val("f4_eop_to_sop", qc(128) - qc(127), 18);
        check_val("f4_done_count", done_cyc.size(), 2);
        check_val("f4_drops", int'(drop_cnt), 2);
        frame_grant = 1'b1;
        idle(25);

        // stalled sink, sample every cycle: drop counter climbs then saturates
        clear_mon();
        fft_sink_ready = 1'b0;
        for (int c = 0; c < 100; c++) begin
            audio_valid = 1'b1;
            audio_data  = 16'(6000 + c);
            tick();
        end
        check_val("f5_drops_mid", int'(drop_cnt), 101);
        check_val("f5_busy", int'(busy), 1);
        check_val("f5_held_data", int'(fft_sink_data), 6000);
        for (int c = 100; c < 300; c++) begin
            audio_data = 16'(6000 + c);
            tick();
        end
        audio_valid = 1'b0;
        check_val("f5_drops_sat", int'(drop_cnt), 255);
        check_val("f5_hold_stable", unstable, 0);
        fft_sink_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_val("f5_drops_cleared", int'(drop_cnt), 0);

        // reset while idx = 60
        clear_mon();
        for (int c = 0; c < 61; c++) begin
            audio_valid = 1'b1;
            audio_data  = 16'(4000 + c);
            tick();
        end
        rst_n      = 1'b0;
        audio_data = 16'(4061);
        tick();
        check_all_zero("midrst");
        check_val("midrst_xfers", x_data.size(), 61);
        check_val("midrst_last", qd(60), 4060);
        rst_n = 1'b1;
        clear_mon();
        for (int k = 0; k < 4; k++) begin
            audio_valid = 1'b1;
            audio_data  = 16'(5000 + k);
            tick();
        end
        audio_valid = 1'b0;
        idle(2);
        check_val("post_xfers", x_data.size(), 4);
        check_val("post_first_data", qd(0), 5000);
        check_val("post_first_sop", qs(0), 1);
        check_val("post_second_sop", qs(1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
